// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use hazard detection.
// Feeds final A, B and opcode to the 32-bit ALU.
module id_ex_operand_stage (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        ID_Valid,
  input  logic [31:0] ID_ReadData1,
  input  logic [31:0] ID_ReadData2,
  input  logic [31:0] ID_Imm,
  input  logic [3:0]  ID_ALUControl,
  input  logic        ID_ALUSrc,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic [4:0]  ID_Rd,
  input  logic        ID_RegDst,
  input  logic        ID_RegWrite,
  input  logic        ID_MemRead,
  input  logic        ID_UsesRt,
  input  logic        MEM_RegWrite,
  input  logic [4:0]  MEM_WriteReg,
  input  logic [31:0] MEM_ALUResult,
  input  logic        WB_RegWrite,
  input  logic [4:0]  WB_WriteReg,
  input  logic [31:0] WB_WriteData,
  output logic [31:0] EX_A,
  output logic [31:0] EX_B,
  output logic [3:0]  EX_ALUControl,
  output logic [31:0] EX_StoreData,
  output logic [4:0]  EX_WriteReg,
  output logic        EX_RegWrite,
  output logic        EX_MemRead,
  output logic        EX_Valid,
  output logic        LoadUseHazard
);

  logic        valid_q, valid_d;
  logic [31:0] rd1_q, rd1_d;
  logic [31:0] rd2_q, rd2_d;
  logic [31:0] imm_q, imm_d;
  logic [3:0]  alu_ctrl_q, alu_ctrl_d;
  logic        alu_src_q, alu_src_d;
  logic [4:0]  rs_q, rs_d;
  logic [4:0]  rt_q, rt_d;
  logic [4:0]  write_reg_q, write_reg_d;
  logic        reg_write_q, reg_write_d;
  logic        mem_read_q, mem_read_d;

  logic [31:0] fwd_a, fwd_b;
  logic        mem_hit_a, wb_hit_a, mem_hit_b, wb_hit_b;

  // Next-state: flush clears to a bubble, stall holds, otherwise capture decode.
  always_comb begin
    valid_d     = valid_q;
    rd1_d       = rd1_q;
    rd2_d       = rd2_q;
    imm_d       = imm_q;
    alu_ctrl_d  = alu_ctrl_q;
    alu_src_d   = alu_src_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    write_reg_d = write_reg_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    if (Flush) begin
      valid_d     = 1'b0;
      rd1_d       = '0;
      rd2_d       = '0;
      imm_d       = '0;
      alu_ctrl_d  = '0;
      alu_src_d   = 1'b0;
      rs_d        = '0;
      rt_d        = '0;
      write_reg_d = '0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
    end else if (!Stall) begin
      valid_d     = ID_Valid;
      rd1_d       = ID_ReadData1;
      rd2_d       = ID_ReadData2;
      imm_d       = ID_Imm;
      alu_ctrl_d  = ID_ALUControl;
      alu_src_d   = ID_ALUSrc;
      rs_d        = ID_Rs;
      rt_d        = ID_Rt;
      write_reg_d = ID_RegDst ? ID_Rd : ID_Rt;
      // Bubbles must never write back or count as loads.
      reg_write_d = ID_RegWrite & ID_Valid;
      mem_read_d  = ID_MemRead & ID_Valid;
    end
  end

  // Pipeline register with synchronous reset taking priority over everything.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q     <= 1'b0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      alu_ctrl_q  <= '0;
      alu_src_q   <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      write_reg_q <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      imm_q       <= imm_d;
      alu_ctrl_q  <= alu_ctrl_d;
      alu_src_q   <= alu_src_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      write_reg_q <= write_reg_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
    end
  end

  // Forwarding muxes: MEM beats WB, register 0 is never forwarded.
  always_comb begin
    mem_hit_a = MEM_RegWrite && (MEM_WriteReg != 5'd0) && (MEM_WriteReg == rs_q);
    wb_hit_a  = WB_RegWrite && (WB_WriteReg != 5'd0) && (WB_WriteReg == rs_q);
    mem_hit_b = MEM_RegWrite && (MEM_WriteReg != 5'd0) && (MEM_WriteReg == rt_q);
    wb_hit_b  = WB_RegWrite && (WB_WriteReg != 5'd0) && (WB_WriteReg == rt_q);
    fwd_a = rd1_q;
    if (mem_hit_a)     fwd_a = MEM_ALUResult;
    else if (wb_hit_a) fwd_a = WB_WriteData;
    fwd_b = rd2_q;
    if (mem_hit_b)     fwd_b = MEM_ALUResult;
    else if (wb_hit_b) fwd_b = WB_WriteData;
  end

  // Output drive and load-use detection against the instruction now in decode.
  always_comb begin
    EX_A          = fwd_a;
    EX_B          = alu_src_q ? imm_q : fwd_b;
    EX_StoreData  = fwd_b;
    EX_ALUControl = alu_ctrl_q;
    EX_WriteReg   = write_reg_q;
    EX_RegWrite   = reg_write_q;
    EX_MemRead    = mem_read_q;
    EX_Valid      = valid_q;
    LoadUseHazard = valid_q && mem_read_q && (write_reg_q != 5'd0) && ID_Valid &&
                    ((ID_Rs == write_reg_q) || (ID_UsesRt && (ID_Rt == write_reg_q)));
  end

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline register and operand-forwarding stage that sits directly upstream of the 32-bit ALU. It captures decoded operands and control from the decode stage on each clock, resolves data hazards by forwarding from MEM and WB, and presents final `A`, `B` and `ALUControl` to the ALU. It also detects load-use hazards and supports pipeline stall and flush.

## Interface
- No parameters. Data width is fixed at 32 and register-index width at 5.
- `Clk` in 1: single clock, rising-edge.
- `Reset` in 1: synchronous, active-high.
- `Stall` in 1: hold the current EX contents.
- `Flush` in 1: insert a bubble.
- `ID_Valid` in 1: decode slot holds a real instruction.
- `ID_ReadData1`, `ID_ReadData2` in 32: register-file read data.
- `ID_Imm` in 32: sign-extended immediate. For SLL, bits [10:6] carry shamt.
- `ID_ALUControl` in 4: ALU opcode (0 AND, 1 OR, 2 ADD, 3 NOR, 6 SUB, 7 SLT, 8 JUMP, 9 MUL, 10 SLL, 11 SGT).
- `ID_ALUSrc` in 1: 1 selects `Imm` as B.
- `ID_Rs`, `ID_Rt`, `ID_Rd` in 5: source and destination indices.
- `ID_RegDst` in 1: 1 selects `Rd` as destination, 0 selects `Rt`.
- `ID_RegWrite` in 1: instruction writes the register file.
- `ID_MemRead` in 1: instruction is a load.
- `ID_UsesRt` in 1: instruction reads `Rt`.
- `MEM_RegWrite` in 1, `MEM_WriteReg` in 5, `MEM_ALUResult` in 32: EX/MEM forwarding source.
- `WB_RegWrite` in 1, `WB_WriteReg` in 5, `WB_WriteData` in 32: MEM/WB forwarding source.
- `EX_A`, `EX_B` out 32: ALU operands.
- `EX_ALUControl` out 4: ALU opcode.
- `EX_StoreData` out 32: forwarded Rt value, used by stores.
- `EX_WriteReg` out 5: destination index.
- `EX_RegWrite`, `EX_MemRead`, `EX_Valid` out 1.
- `LoadUseHazard` out 1: request to stall upstream.

## Operation
- **Registered fields:** Valid, RD1, RD2, Imm, ALUControl, ALUSrc, Rs, Rt, WriteReg, RegWrite, MemRead.
  - WriteReg = `ID_RegDst ? ID_Rd : ID_Rt`, resolved at capture.
  - RegWrite and MemRead are captured ANDed with `ID_Valid`.
- **Update priority on each rising `Clk`:** Reset > Flush > Stall > load.
  - Reset and Flush both clear all registered fields to 0. This yields ALUControl 0000 (AND of 0,0 gives result 0), RegWrite 0, MemRead 0, Valid 0.
  - Stall holds every registered field.
- **Forwarding for A** (combinational, from registered Rs):
  - If `MEM_RegWrite && MEM_WriteReg != 0 && MEM_WriteReg == Rs`, use `MEM_ALUResult`.
  - Else if `WB_RegWrite && WB_WriteReg != 0 && WB_WriteReg == Rs`, use `WB_WriteData`.
  - Else use RD1.
- **Forwarded Rt value** uses the same rule against Rt, falling back to RD2. It drives `EX_StoreData`.
- **`EX_B`** = registered Imm when ALUSrc = 1, otherwise the forwarded Rt value.
- **Register 0** is never forwarded. MEM has priority over WB when both match.
- **Load-use hazard:** `LoadUseHazard = EX_Valid && EX_MemRead && WriteReg != 0 && ID_Valid && (ID_Rs == WriteReg || (ID_UsesRt && ID_Rt == WriteReg))`. This is combinational.
  - The block does not self-stall. The upstream hazard controller is expected to drive `Stall` for the IF/ID stages and `Flush` for this stage on the same cycle.

## Timing
- Latency: ID inputs appear on the EX outputs one cycle after the capturing edge.
- Forwarding and `LoadUseHazard` are zero-latency combinational paths from the registered fields and the current MEM/WB and ID inputs.
- Reset values:
  - All outputs are 0 while reset fields are held.
  - `EX_A`, `EX_B` and `EX_StoreData` can still reflect forwarded data only if MEM/WB match register 0, which is excluded, so they are 0.
- Flush asserted together with Stall: the bubble wins.
- Reset asserted mid-stall: clears on that edge.
- `ID_Valid` = 0 while loading: captures a bubble with Valid 0 and RegWrite 0. Data fields are still captured and are don't-care.
- Stall with changing MEM/WB inputs: outputs re-forward each cycle. Held fields are not overwritten with forwarded values.

## Test plan
- **Reset:** Reset=1 for 2 cycles with arbitrary ID inputs. Expect all EX outputs 0 and `LoadUseHazard` 0.
- **Plain load:** ID ADD, RD1=5, RD2=7, ALUSrc=0, Rd=3, RegDst=1, RegWrite=1, Valid=1; one edge. Expect `EX_A`=5, `EX_B`=7, `EX_ALUControl`=2, `EX_WriteReg`=3, `EX_RegWrite`=1.
- **Double forwarding:** EX holds Rs=4, Rt=4, ALUSrc=0; MEM writes r4=0x11 and WB writes r4=0x22. Expect A=B=0x11. Drop MEM_RegWrite: expect 0x22. Set MEM_WriteReg=0 with Rs=0: expect RD1.
- **SLL immediate:** ALUControl=10, ALUSrc=1, Imm=0x00000100 (shamt 4), Rt forwarded from MEM=0xAB. Expect `EX_B`=0x100 and `EX_StoreData`=0xAB.
- **Load-use hazard:** EX holds MemRead=1, WriteReg=9; ID has Rs=9. Expect `LoadUseHazard`=1. Set ID Rt=9 with `ID_UsesRt`=0 and Rs=1: expect 0.
- **Stall and flush:** Stall=1 for 3 cycles with changing ID inputs: EX fields stay constant. Then Stall=1 and Flush=1 together: the next edge gives Valid=0, RegWrite=0, ALUControl=0.
